// File: rtl/fifo_reader.sv
// Read side of an asynchronous FIFO: synchronizes the write pointer, derives empty and
// fill level, addresses the memory and presents words through a registered valid/ready stage.
module fifo_reader #(
    parameter int unsigned DATA_SIZE = 4,
    parameter int unsigned ADDR_SIZE = 4
) (
    input  logic                 rd_clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE:0]   wr_ptr_gray,
    input  logic [DATA_SIZE-1:0] rd_data_mem,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic [ADDR_SIZE:0]   rd_ptr_gray,
    output logic [DATA_SIZE-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 empty,
    output logic [ADDR_SIZE:0]   rd_level
);
    localparam int unsigned PTR_W = ADDR_SIZE + 1;

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] wq1;
    logic [PTR_W-1:0] wq2;
    logic [PTR_W-1:0] wbin_s;
    logic             fetch;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < PTR_W; i++) begin : g_gray2bin
        assign wbin_s[i] = ^(wq2 >> i);
    end

    assign rbin_next = rbin + PTR_W'(1);
    assign empty     = (rd_ptr_gray == wq2);
    assign rd_level  = wbin_s - rbin;
    assign rd_addr   = rbin[ADDR_SIZE-1:0];
    assign fetch     = !empty && (!m_valid || m_ready);

    // Synchronizer, read pointer and output stage; a fetch replaces the held word without a bubble.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            wq1         <= '0;
            wq2         <= '0;
            rbin        <= '0;
            rd_ptr_gray <= '0;
            m_data      <= '0;
            m_valid     <= 1'b0;
        end else begin
            wq1 <= wr_ptr_gray;
            wq2 <= wq1;
            if (fetch) begin
                m_data      <= rd_data_mem;
                m_valid     <= 1'b1;
                rbin        <= rbin_next;
                rd_ptr_gray <= rbin_next ^ (rbin_next >> 1);
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: directed scenarios plus randomized traffic, checked
// every cycle against a word-count model of the read side and a queue of written words.
module tb_fifo_reader;
    localparam int unsigned DW    = 4;
    localparam int unsigned AW    = 4;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic          rd_clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] wr_ptr_gray = '0;
    logic [DW-1:0] rd_data_mem;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_ptr_gray;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          empty;
    logic [PW-1:0] rd_level;

    logic [DW-1:0] mem [DEPTH];
    assign rd_data_mem = mem[rd_addr];

    fifo_reader #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
        .rd_clk      (rd_clk),
        .rst         (rst),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_data_mem (rd_data_mem),
        .rd_addr     (rd_addr),
        .rd_ptr_gray (rd_ptr_gray),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .empty       (empty),
        .rd_level    (rd_level)
    );

    always #5 rd_clk = ~rd_clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] from_gray(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Reference: counts of words written, visible after two edges, and fetched.
    logic [PW-1:0] mw1 = '0;
    logic [PW-1:0] mw2 = '0;
    logic [PW-1:0] mrb = '0;
    logic          mmv = 1'b0;

    always @(posedge rd_clk) begin
        if (rst) begin
            mw1 <= '0;
            mw2 <= '0;
            mrb <= '0;
            mmv <= 1'b0;
        end else begin
            mw1 <= from_gray(wr_ptr_gray);
            mw2 <= mw1;
            if (mrb != mw2 && (!mmv || m_ready)) begin
                mrb <= mrb + PW'(1);
                mmv <= 1'b1;
            end else if (mmv && m_ready) begin
                mmv <= 1'b0;
            end
        end
    end

    logic [DW-1:0] exp_q [$];
    logic [PW-1:0] wptr = '0;
    logic [PW-1:0] prev_gray = '0;
    logic          prev_rst = 1'b1;
    bit            mon_en = 1'b0;

    // Monitor: compares every cycle and retires scoreboard words on accepted handshakes.
    always @(negedge rd_clk) begin
        if (mon_en) begin
            chk("m_valid", 32'(m_valid), 32'(mmv));
            chk("rd_addr", 32'(rd_addr), 32'(mrb[AW-1:0]));
            chk("rd_ptr_gray", 32'(rd_ptr_gray), 32'(to_gray(mrb)));
            chk("empty", 32'(empty), 32'(mrb == mw2));
            chk("rd_level", 32'(rd_level), 32'(PW'(mw2 - mrb)));
            if (!prev_rst)
                chk("gray_step", 32'($countones(rd_ptr_gray ^ prev_gray) <= 1), 32'(1));
            if (!rst && mmv) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'(1));
                end else begin
                    chk("m_data", 32'(m_data), 32'(exp_q[0]));
                    if (m_ready) void'(exp_q.pop_front());
                end
            end
        end
        prev_rst  <= rst;
        prev_gray <= rd_ptr_gray;
    end

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        mem[wptr[AW-1:0]] = d;
        exp_q.push_back(d);
        wptr = wptr + PW'(1);
        wr_ptr_gray = to_gray(wptr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_ready = 1'b0;
        wptr = '0;
        wr_ptr_gray = '0;
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        m_ready = 1'b1;
        for (int t = 0; t < 200 && (exp_q.size() != 0 || m_valid); t++) step();
        chk(name, 32'(exp_q.size()), 32'(0));
        m_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;

        // Reset with idle write pointer, then with wr_ptr_gray=5 held during reset.
        step();
        mon_en = 1'b1;
        step();
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_rd_addr", 32'(rd_addr), 32'(0));
        chk("rst_rd_ptr_gray", 32'(rd_ptr_gray), 32'(0));
        chk("rst_rd_level", 32'(rd_level), 32'(0));
        chk("rst_m_data", 32'(m_data), 32'(0));
        rst = 1'b0;
        step();
        rst = 1'b1;
        wr_ptr_gray = 5'd5;
        step();
        chk("rst5_m_valid", 32'(m_valid), 32'(0));
        chk("rst5_empty", 32'(empty), 32'(1));
        chk("rst5_rd_level", 32'(rd_level), 32'(0));
        chk("rst5_rd_ptr_gray", 32'(rd_ptr_gray), 32'(0));
        wr_ptr_gray = '0;
        step();
        rst = 1'b0;

        // Single word and its latency.
        push_word(4'hA);
        step();
        chk("sw_empty_k", 32'(empty), 32'(1));
        step();
        chk("sw_empty_k1", 32'(empty), 32'(0));
        chk("sw_valid_k1", 32'(m_valid), 32'(0));
        step();
        chk("sw_valid_k2", 32'(m_valid), 32'(1));
        chk("sw_data_k2", 32'(m_data), 32'(4'hA));
        chk("sw_gray_k2", 32'(rd_ptr_gray), 32'(1));
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("sw_valid_after", 32'(m_valid), 32'(0));
        chk("sw_empty_after", 32'(empty), 32'(1));

        // Backpressure with three words.
        do_reset();
        push_word(4'h1);
        step();
        push_word(4'h2);
        step();
        push_word(4'h3);
        repeat (5) step();
        chk("bp_data_held", 32'(m_data), 32'(4'h1));
        chk("bp_valid", 32'(m_valid), 32'(1));
        chk("bp_rd_addr", 32'(rd_addr), 32'(1));
        chk("bp_rd_level", 32'(rd_level), 32'(2));
        m_ready = 1'b1;
        step();
        chk("bp_data2", 32'(m_data), 32'(4'h2));
        step();
        chk("bp_data3", 32'(m_data), 32'(4'h3));
        chk("bp_valid3", 32'(m_valid), 32'(1));
        step();
        chk("bp_valid_end", 32'(m_valid), 32'(0));
        m_ready = 1'b0;

        // Wrap: 40 words stream through, rbin ends at 40 mod 32 = 8.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int t = 0; t < 50 && PW'(wptr - mrb) >= DEPTH; t++) step();
            push_word(DW'(i % 16));
            step();
        end
        drain("wrap_drained");
        chk("wrap_rd_ptr_gray", 32'(rd_ptr_gray), 32'(5'h0C));
        chk("wrap_rd_addr", 32'(rd_addr), 32'(8));

        // Full level: 16 visible words must read as 16, not 0.
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) push_word(DW'($urandom));
        w0 = exp_q[0];
        chk("full_wr_gray", 32'(wr_ptr_gray), 32'(5'h18));
        step();
        step();
        chk("full_level16", 32'(rd_level), 32'(16));
        chk("full_empty", 32'(empty), 32'(0));
        step();
        chk("full_level15", 32'(rd_level), 32'(15));
        chk("full_data", 32'(m_data), 32'(w0));
        chk("full_valid", 32'(m_valid), 32'(1));

        // Mid-stream reset with a word pending and m_ready high: reset wins over fetch.
        m_ready = 1'b1;
        repeat (10) step();
        chk("mid_level5", 32'(rd_level), 32'(5));
        chk("mid_valid", 32'(m_valid), 32'(1));
        rst = 1'b1;
        wptr = '0;
        wr_ptr_gray = '0;
        exp_q.delete();
        step();
        chk("mid_rst_valid", 32'(m_valid), 32'(0));
        chk("mid_rst_gray", 32'(rd_ptr_gray), 32'(0));
        chk("mid_rst_addr", 32'(rd_addr), 32'(0));
        chk("mid_rst_data", 32'(m_data), 32'(0));
        rst = 1'b0;
        m_ready = 1'b0;
        step();

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 800; c++) begin
            m_ready = ($urandom_range(3) != 0);
            if ($urandom_range(1) == 1 && PW'(wptr - mrb) < DEPTH) push_word(DW'($urandom));
            step();
        end
        drain("random_drained");
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
